// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage with dmem req/gnt/rvalid handshake, load align/extend and MEM/WB register.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing them aligned.
module load_store_unit #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_m_i,
  input  logic               mem_read_m_i,
  input  logic               mem_write_m_i,
  input  logic [2:0]         funct3_m_i,
  input  logic [D_WIDTH-1:0] alu_result_m_i,
  input  logic [D_WIDTH-1:0] write_data_m_i,
  input  logic               reg_write_m_i,
  input  logic [1:0]         result_src_m_i,
  input  logic [4:0]         rd_m_i,
  input  logic [D_WIDTH-1:0] pc_plus4_m_i,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [D_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]         dmem_be_o,
  output logic [D_WIDTH-1:0] dmem_wdata_o,
  input  logic               dmem_gnt_i,
  input  logic               dmem_rvalid_i,
  input  logic [D_WIDTH-1:0] dmem_rdata_i,
  output logic               stall_m_o,
  output logic               reg_write_w_o,
  output logic [1:0]         result_src_w_o,
  output logic [D_WIDTH-1:0] alu_result_w_o,
  output logic [D_WIDTH-1:0] read_data_w_o,
  output logic [4:0]         rd_w_o,
  output logic [D_WIDTH-1:0] pc_plus4_w_o,
  output logic               misalign_w_o
);
  typedef enum logic {REQ, WAIT} state_t;
  state_t             state_q;
  logic [1:0]         off_q;
  logic [2:0]         f3_q;
  logic               reg_write_q, misalign_q;
  logic [1:0]         result_src_q;
  logic [4:0]         rd_q;
  logic [D_WIDTH-1:0] alu_q, rdata_q, pc4_q, ld;
  logic               legal, is_w, is_h, mem_op, trap, pending, is_load, bubble, done;
  logic [1:0]         off;
  logic [7:0]         lb;
  logic [15:0]        lh;
  assign legal   = funct3_m_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign is_w    = funct3_m_i == 3'b010;
  assign is_h    = funct3_m_i[1:0] == 2'b01;
  assign is_load = mem_read_m_i;
  assign mem_op  = valid_m_i & (mem_read_m_i | mem_write_m_i) & legal;
`ifdef MISALIGN_TRAP_EN
  assign trap = mem_op & ((is_w & |alu_result_m_i[1:0]) | (is_h & alu_result_m_i[0]));
`else
  assign trap = 1'b0;
`endif
  // Offending low bits are dropped so lanes always line up with the access size
  assign off     = is_w ? 2'b00 : is_h ? {alu_result_m_i[1], 1'b0} : alu_result_m_i[1:0];
  assign pending = mem_op & ~trap;
  assign done    = state_q == WAIT & dmem_rvalid_i;
  assign stall_m_o    = state_q == WAIT ? ~dmem_rvalid_i : pending & ~(dmem_gnt_i & ~is_load);
  assign dmem_req_o   = state_q == REQ & pending;
  assign dmem_we_o    = dmem_req_o & ~is_load;
  assign dmem_addr_o  = {alu_result_m_i[D_WIDTH-1:2], 2'b00};
  assign dmem_be_o    = is_w ? 4'hF : is_h ? (off[1] ? 4'hC : 4'h3) : 4'b0001 << off;
  assign dmem_wdata_o = is_w ? write_data_m_i : is_h ? {2{write_data_m_i[15:0]}} : {4{write_data_m_i[7:0]}};
  assign lb = dmem_rdata_i[8*off_q +: 8];
  assign lh = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
  assign ld = f3_q[1] ? dmem_rdata_i : f3_q[0] ? {{16{~f3_q[2] & lh[15]}}, lh} : {{24{~f3_q[2] & lb[7]}}, lb};
  assign bubble = stall_m_o | ~valid_m_i | ~legal;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= REQ;
      off_q        <= '0;
      f3_q         <= '0;
      reg_write_q  <= 1'b0;
      misalign_q   <= 1'b0;
      result_src_q <= '0;
      alu_q        <= '0;
      rdata_q      <= '0;
      rd_q         <= '0;
      pc4_q        <= '0;
    end else begin
      if (state_q == REQ && pending && dmem_gnt_i && is_load) begin
        state_q <= WAIT;
        off_q   <= off;
        f3_q    <= funct3_m_i;
      end else if (done) begin
        state_q <= REQ;
      end
      reg_write_q  <= ~bubble & ~trap & reg_write_m_i;
      misalign_q   <= ~bubble & trap;
      result_src_q <= bubble ? '0 : result_src_m_i;
      alu_q        <= bubble ? '0 : alu_result_m_i;
      rd_q         <= bubble ? '0 : rd_m_i;
      pc4_q        <= bubble ? '0 : pc_plus4_m_i;
      rdata_q      <= (~bubble & done) ? ld : '0;
    end
  end
  assign reg_write_w_o  = reg_write_q;
  assign misalign_w_o   = misalign_q;
  assign result_src_w_o = result_src_q;
  assign alu_result_w_o = alu_q;
  assign read_data_w_o  = rdata_q;
  assign rd_w_o         = rd_q;
  assign pc_plus4_w_o   = pc4_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed stimulus for load_store_unit with a transaction-level reference model checked every cycle.
module tb_load_store_unit;
  logic clk = 0, rst = 1;
  logic valid, mrd, mwr, rw, gnt, rvalid;
  logic [2:0] f3;
  logic [1:0] rs;
  logic [4:0] rdn;
  logic [31:0] alu, wd, pc4, rdata;
  logic req, we, stall, rw_w, mis_w;
  logic [31:0] addr, wdata, alu_w, rd_w, pc4_w;
  logic [3:0] be;
  logic [1:0] rs_w;
  logic [4:0] rdn_w;
  int total = 0, bad = 0, nst, b_off;
  bit armed = 0, busy = 0;
  logic [2:0] b_f3;
  logic e_rw, e_mis, e_rdchk;
  logic [1:0] e_rs;
  logic [4:0] e_rdn;
  logic [31:0] e_alu, e_pc4, e_rdata, r;
  logic [2:0] lf [6] = '{3'd5, 3'd1, 3'd1, 3'd4, 3'd0, 3'd2};
  logic [31:0] la [6] = '{32'h002, 32'h006, 32'h004, 32'h001, 32'h003, 32'h008};
  logic [31:0] ld [6] = '{32'hBEEF1234, 32'h80017FFF, 32'h80017FFF, 32'h0000F000, 32'h7F000000, 32'hDEADBEEF};
  logic [31:0] le [6] = '{32'h0000BEEF, 32'hFFFF8001, 32'h00007FFF, 32'h000000F0, 32'h0000007F, 32'hDEADBEEF};

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .valid_m_i(valid), .mem_read_m_i(mrd), .mem_write_m_i(mwr),
    .funct3_m_i(f3), .alu_result_m_i(alu), .write_data_m_i(wd), .reg_write_m_i(rw),
    .result_src_m_i(rs), .rd_m_i(rdn), .pc_plus4_m_i(pc4),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_be_o(be), .dmem_wdata_o(wdata),
    .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata), .stall_m_o(stall),
    .reg_write_w_o(rw_w), .result_src_w_o(rs_w), .alu_result_w_o(alu_w), .read_data_w_o(rd_w),
    .rd_w_o(rdn_w), .pc_plus4_w_o(pc4_w), .misalign_w_o(mis_w)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic int aoff(input logic [31:0] a, input int s);
    return int'(a % 4) / s * s;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] d, input int off, input logic [2:0] f);
    logic [31:0] v;
    v = d >> (8 * off);
    case (f)
      3'd0:    return (v & 255) >= 128 ? (v & 255) + 32'hFFFFFF00 : v & 255;
      3'd4:    return v & 255;
      3'd1:    return (v & 65535) >= 32768 ? (v & 65535) + 32'hFFFF0000 : v & 65535;
      3'd5:    return v & 65535;
      default: return d;
    endcase
  endfunction

  // Expected request/stall for the instruction currently presented, given whether a load is outstanding
  function automatic void model(output bit q, output bit s, output bit t, output bit l);
    int sz;
    bit memop;
    sz = size_of(f3);
    memop = valid && (mrd || mwr) && sz != 0;
`ifdef MISALIGN_TRAP_EN
    t = memop && (alu % sz) != 0;
`else
    t = 0;
`endif
    l = mrd;
    q = !busy && memop && !t;
    s = busy ? !rvalid : (q && !(gnt && !l));
  endfunction

  always @(posedge clk) begin : mdl
    bit q, s, t, l;
    model(q, s, t, l);
    if (rst) begin
      armed <= 1; busy <= 0;
      e_rw <= 0; e_mis <= 0; e_rs <= 0; e_alu <= 0; e_rdn <= 0; e_pc4 <= 0; e_rdata <= 0; e_rdchk <= 1;
    end else begin
      if (s || !valid || size_of(f3) == 0) begin
        e_rw <= 0; e_mis <= 0; e_rs <= 0; e_alu <= 0; e_rdn <= 0; e_pc4 <= 0; e_rdata <= 0; e_rdchk <= 1;
      end else begin
        e_rw <= rw && !t; e_mis <= t; e_rs <= rs; e_alu <= alu; e_rdn <= rdn; e_pc4 <= pc4;
        e_rdata <= extract(rdata, b_off, b_f3); e_rdchk <= busy;
      end
      if (busy && rvalid) busy <= 0;
      else if (q && gnt && l) begin
        busy <= 1; b_off <= aoff(alu, size_of(f3)); b_f3 <= f3;
      end
    end
  end

  always @(negedge clk) if (armed) begin : cmp
    bit q, s, t, l;
    int sz;
    model(q, s, t, l);
    chk("req", 32'(req), 32'(q));
    chk("stall", 32'(stall), 32'(s));
    if (q) begin
      sz = size_of(f3);
      chk("we", 32'(we), 32'(!l));
      chk("addr", addr, alu - alu % 4);
      if (!l) begin
        chk("be", 32'(be), ((1 << sz) - 1) << aoff(alu, sz));
        chk("wdata", wdata, sz == 1 ? (wd & 255) * 32'h01010101 : sz == 2 ? (wd & 65535) * 32'h00010001 : wd);
      end
    end
    chk("reg_write_w", 32'(rw_w), 32'(e_rw));
    chk("misalign_w", 32'(mis_w), 32'(e_mis));
    chk("result_src_w", 32'(rs_w), 32'(e_rs));
    chk("alu_result_w", alu_w, e_alu);
    chk("rd_w", 32'(rdn_w), 32'(e_rdn));
    chk("pc_plus4_w", pc4_w, e_pc4);
    if (e_rdchk) chk("read_data_w", rd_w, e_rdata);
  end

  task automatic setop(input logic v, input logic r, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d, input logic en, input logic [4:0] dst);
    valid = v; mrd = r; mwr = w; f3 = f; alu = a; wd = d; rw = en; rdn = dst;
    rs = r ? 2'd1 : 2'd0; pc4 = a + 32'h1000;
  endtask

  task automatic mem(input logic g, input logic v, input logic [31:0] d);
    gnt = g; rvalid = v; rdata = d; #1;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle;
    setop(0, 0, 0, 0, 0, 0, 0, 0); mem(0, 0, 0);
  endtask

  task automatic do_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d, output logic [31:0] res);
    setop(1, 1, 0, f, a, 0, 1, 9); mem(1, 0, 0); tick;
    mem(0, 1, d); tick;
    res = rd_w;
    idle;
  endtask

  initial begin
    setop(0, 0, 0, 0, 0, 0, 0, 0); gnt = 0; rvalid = 0; rdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    mem(0, 0, 0);
    chk("rst_reg_write", 32'(rw_w), 0);
    chk("rst_alu", alu_w, 0);
    chk("rst_misalign", 32'(mis_w), 0);
    chk("rst_req", 32'(req), 0);
    chk("rst_stall", 32'(stall), 0);
    setop(1, 0, 0, 0, 32'h1234, 0, 1, 5); mem(0, 0, 0);
    chk("add_stall", 32'(stall), 0);
    chk("add_req", 32'(req), 0);
    tick;
    chk("add_alu_w", alu_w, 32'h1234);
    chk("add_rw_w", 32'(rw_w), 1);
    setop(1, 0, 1, 0, 32'h103, 32'hAB, 0, 0); mem(1, 0, 0);
    chk("sb_addr", addr, 32'h100);
    chk("sb_be", 32'(be), 32'b1000);
    chk("sb_wdata", wdata, 32'hABABABAB);
    chk("sb_stall", 32'(stall), 0);
    tick;
    setop(1, 1, 0, 0, 32'h102, 0, 1, 7); nst = 0;
    for (int i = 0; i < 6; i++) begin
      mem(i == 2, i == 5, i == 5 ? 32'h00800000 : 32'h0);
      if (stall) nst++;
      tick;
    end
    chk("lb_stall_cycles", 32'(nst), 5);
    chk("lb_data", rd_w, 32'hFFFFFF80);
    chk("lb_rw_w", 32'(rw_w), 1);
    idle; tick;
    chk("lb_rw_once", 32'(rw_w), 0);
    for (int i = 0; i < 6; i++) begin
      do_load(lf[i], la[i], ld[i], r);
      chk($sformatf("load%0d", i), r, le[i]);
    end
    setop(1, 0, 1, 1, 32'h102, 32'h1234ABCD, 0, 0); mem(0, 0, 0);
    chk("sh_wait_stall", 32'(stall), 1);
    tick; mem(1, 0, 0);
    chk("sh_be", 32'(be), 32'hC);
    chk("sh_wdata", wdata, 32'hABCDABCD);
    tick;
    setop(1, 0, 1, 2, 32'h200, 32'hCAFEF00D, 0, 0); mem(1, 0, 0);
    chk("sw_be", 32'(be), 32'hF);
    tick;
`ifdef MISALIGN_TRAP_EN
    setop(1, 1, 0, 2, 32'h5, 0, 1, 3); mem(0, 0, 0);
    chk("mis_req", 32'(req), 0);
    chk("mis_stall", 32'(stall), 0);
    tick;
    chk("mis_flag", 32'(mis_w), 1);
    chk("mis_rw_w", 32'(rw_w), 0);
    idle; tick;
    chk("mis_once", 32'(mis_w), 0);
`else
    setop(1, 1, 0, 2, 32'h5, 0, 1, 3); mem(1, 0, 0);
    chk("mis_addr", addr, 32'h4);
    tick; mem(0, 1, 32'h11223344); tick;
    chk("mis_lw_data", rd_w, 32'h11223344);
    chk("mis_flag", 32'(mis_w), 0);
    setop(1, 0, 1, 1, 32'h101, 32'h5678, 0, 0); mem(1, 0, 0);
    chk("mis_sh_be", 32'(be), 32'h3);
    tick;
`endif
    setop(1, 1, 0, 3'b011, 32'h40, 0, 1, 4); mem(1, 0, 0);
    chk("illegal_req", 32'(req), 0);
    tick;
    chk("illegal_rw_w", 32'(rw_w), 0);
    setop(1, 1, 1, 2, 32'h20, 32'h55, 1, 6); mem(1, 0, 0);
    chk("both_we", 32'(we), 0);
    tick; mem(0, 1, 32'h77); tick;
    chk("both_data", rd_w, 32'h77);
    setop(1, 1, 0, 2, 32'h10, 0, 1, 8); mem(1, 0, 0); tick;
    rst = 1; mem(0, 0, 0); tick;
    rst = 0; setop(0, 0, 0, 0, 0, 0, 0, 0); mem(0, 1, 32'h99);
    chk("late_rvalid_stall", 32'(stall), 0);
    tick;
    chk("abandon_rw_w", 32'(rw_w), 0);
    chk("abandon_data", rd_w, 0);
    setop(1, 0, 0, 0, 32'h55AA, 0, 1, 2); mem(0, 0, 0);
    chk("after_rst_req", 32'(req), 0);
    tick;
    chk("after_rst_alu", alu_w, 32'h55AA);
    idle; repeat (2) tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory stage of the pipelined RV32I core: turns the execute result of a load or store into a data-memory transaction, aligns and extends load data, and registers everything the writeback stage needs (MEM/WB pipeline register). Data memory uses a request/grant plus response-valid handshake, so the block holds the pipeline with `stall_m_o` until the access completes. Outputs feed writeback directly.

## Interface
- `D_WIDTH`, 32, datapath and address width; only 32 is supported.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_m_i` in 1: memory-stage instruction valid.
- `mem_read_m_i` / `mem_write_m_i` in 1: load / store; both high means load wins.
- `funct3_m_i` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are a no-op bubble.
- `alu_result_m_i` in 32: effective address, or ALU result for non-memory ops.
- `write_data_m_i` in 32: store data (rs2).
- `reg_write_m_i` in 1, `result_src_m_i` in 2, `rd_m_i` in 5, `pc_plus4_m_i` in 32: control passed through to writeback.
- `dmem_req_o` out 1, `dmem_we_o` out 1, `dmem_addr_o` out 32 (bits [1:0] = 0), `dmem_be_o` out 4, `dmem_wdata_o` out 32: request channel.
- `dmem_gnt_i` in 1: request accepted this cycle.
- `dmem_rvalid_i` in 1, `dmem_rdata_i` in 32: load response, earliest one cycle after grant.
- `stall_m_o` out 1: combinational; freezes upstream stages, whose inputs stay stable while high.
- `reg_write_w_o` 1, `result_src_w_o` 2, `alu_result_w_o` 32, `read_data_w_o` 32, `rd_w_o` 5, `pc_plus4_w_o` 32: registered outputs to writeback.
- `misalign_w_o` out 1: registered misalignment flag. Always 0 without the configuration macro.

## Operation
- Access pending = `valid_m_i` & (`mem_read_m_i` | `mem_write_m_i`) & legal funct3 & not trapped-misaligned.
- The FSM has two states, REQ (reset state) and WAIT.
- In REQ:
  - If an access is pending, drive `dmem_req_o`=1 with address, enables and data.
  - On `dmem_gnt_i`, a store completes; a load moves to WAIT.
- In WAIT:
  - `dmem_req_o`=0.
  - On `dmem_rvalid_i`, the load completes and the FSM returns to REQ.
- `stall_m_o`:
  - In REQ: pending & !(gnt & store).
  - In WAIT: !`dmem_rvalid_i`.
  - Otherwise 0.
- MEM/WB register:
  - Loads on every edge where `stall_m_o`=0.
  - While stalled, it loads a bubble (`reg_write_w_o`=0, `misalign_w_o`=0).
  - `valid_m_i`=0 or an illegal funct3 also loads a bubble.
- Store lanes (`dmem_wdata_o`, `dmem_be_o`):
  - SB: wdata = {4{byte}}, be = 0001 << addr[1:0].
  - SH: wdata = {2{half}}, be = addr[1] ? 1100 : 0011.
  - SW: be = 1111.
- Load data, selected using the latched addr[1:0]:
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- Misaligned access: LW/SW with addr[1:0]≠0; LH/LHU/SH with addr[0]=1. Handling is set by the configuration macro.
- A late `dmem_rvalid_i` seen in REQ is ignored.

## Timing
- Reset values: state REQ, all `*_w_o` = 0, `misalign_w_o` = 0. With no pending access, `dmem_req_o` = 0 and `stall_m_o` = 0.
- Reset in WAIT abandons the transaction. No writeback occurs for the abandoned load.
- Non-memory ops: 1-cycle latency, no stall.
- Store granted in the same cycle: 1 cycle, no stall.
- Load: grant cycle + N wait cycles; result appears in writeback the edge after `dmem_rvalid_i`.
- `dmem_req_o` is held, and request fields are held stable, until `dmem_gnt_i`.

## Configuration
- `MISALIGN_TRAP_EN` defined: a misaligned access issues no request and causes no stall. The instruction enters MEM/WB with `reg_write_w_o`=0 and `misalign_w_o`=1 for one cycle.
- `MISALIGN_TRAP_EN` undefined: offending low address bits are forced to 0, then the access proceeds normally. `misalign_w_o` is tied 0.

## Test plan
- Add (`mem_read`=`mem_write`=0), `alu_result`=0x1234 → next cycle `alu_result_w_o`=0x1234, `stall_m_o`=0, `dmem_req_o`=0.
- SB to 0x103, data 0xAB, gnt same cycle → `dmem_addr_o`=0x100, `dmem_be_o`=1000, `dmem_wdata_o`=0xABABABAB, no stall.
- LB from 0x102, gnt delayed 2 cycles, rvalid 3 cycles later with rdata 0x00800000 → `stall_m_o` high 5 cycles, then `read_data_w_o`=0xFFFFFF80, `reg_write_w_o`=1 for one cycle only.
- LHU from 0x002, rdata 0xBEEF1234 → `read_data_w_o`=0x0000BEEF.
- LW from 0x005 with `MISALIGN_TRAP_EN` → no request, `misalign_w_o`=1, `reg_write_w_o`=0. Without the macro → `dmem_addr_o`=0x004.
- Assert `rst` while in WAIT, then give rvalid next cycle → all `*_w_o` remain 0, state REQ.
